mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Byte-serial memory controller between the CPU core and the 8-bit synchronous RAM/IO bus. Accepts word instruction fetches and 1/2/4-byte loads/stores, serialises them into per-byte bus cycles, and reassembles or sign-extends read data. The RAM and IO mux sit directly downstream on `mem_a`/`mem_dout`/`mem_wr`/`mem_din`. The instruction fetch unit and the load/store buffer sit upstream.

## Interface
- `IO_SEL` = 2'b11: value of `addr[17:16]` that marks the IO region.
- `clk_in` in 1: system clock; the block uses this single clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global ready; while low, all state is frozen.
- `mem_din` in 8: read byte from RAM/IO; valid the cycle after its address was presented.
- `mem_dout` out 8: write byte.
- `mem_a` out 32: byte address.
- `mem_wr` out 1: 1 = write, 0 = read.
- `io_buffer_full` in 1: UART TX buffer full.
- `flush_in` in 1: abort the outstanding instruction fetch (mispredict).
- `if_req_valid` in 1, `if_req_addr` in 32: word fetch request.
- `if_resp_valid` out 1, `if_resp_data` out 32: fetch result, 1-cycle pulse.
- `ls_req_valid` in 1, `ls_req_we` in 1, `ls_req_size` in 2, `ls_req_signed` in 1, `ls_req_addr` in 32, `ls_req_wdata` in 32: data request.
  - `ls_req_size` encoding: 0 = byte, 1 = half, 2 = word.
- `ls_resp_valid` out 1, `ls_resp_rdata` out 32: load data or store-done, 1-cycle pulse.

## Operation
- **Handshake.** The requester holds valid and all fields stable until its resp pulse. There is no separate ready signal. Acceptance happens only in IDLE.
- **Arbitration in IDLE.** `ls_req_valid` wins over `if_req_valid`. An `if_req` is ignored in any cycle where `flush_in` is high.
- **States:**
  - IDLE → READ on an accepted load or fetch.
  - IDLE → WRITE on an accepted store.
  - READ/WRITE → IDLE after the response pulse or an abort.
- **Counters.** Byte count N = 1/2/4 by size; a fetch is always 4. A byte counter k tracks issue and a second index tracks capture.
- **READ.**
  - Issue `mem_a` = addr+k with `mem_wr` = 0 for k = 0..N-1.
  - Byte k is captured from `mem_din` one cycle after issue into lane k (little-endian).
  - Upper bytes for size<4 are sign-extended when `ls_req_signed`, otherwise zero-filled.
- **WRITE.**
  - Drive `mem_wr` = 1, `mem_a` = addr+k, `mem_dout` = wdata[8k+7:8k] for k = 0..N-1.
  - IO stall: if the address is IO (`addr[17:16]` == `IO_SEL`) and `io_buffer_full` = 1 when a byte would issue, drive `mem_wr` = 0 that cycle and retry. The byte is not advanced.
- **IO read protection.** Outside an active read, `mem_a` is driven to 0 so that the IO input port is never read spuriously.
- **Flush.**
  - `flush_in` during a fetch READ aborts it: no `if_resp_valid`; IDLE next cycle.
  - Data accesses ignore `flush_in`.
- **rdy_in low.** All registers hold. `mem_wr` output = registered `mem_wr` AND `rdy_in`, so no byte is written twice.
- **Alignment.** Misaligned accesses are not checked. The address increments byte-wise with 32-bit wrap.

## Timing
- **Reset values (1 cycle, `rst_in` high):**
  - state = IDLE.
  - `mem_a` = 0, `mem_dout` = 0, `mem_wr` = 0.
  - `if_resp_valid` = 0, `ls_resp_valid` = 0.
  - `if_resp_data` = 0, `ls_resp_rdata` = 0.
- Reset mid-transfer abandons the access; no response pulse is produced.
- Edge T0 is the accept edge.
- **Read:**
  - `mem_a` = addr+k in the cycle after edge T0+k.
  - Byte k is captured at edge T0+k+2.
  - resp_valid and data are registered at edge T0+N+1.
  - Word latency: resp is high in the 6th cycle after the accept cycle.
- **Write:**
  - Byte k is on the bus in the cycle after edge T0+k, plus any IO stall cycles.
  - `ls_resp_valid` is high in the cycle after the last byte, with `mem_wr` = 0.
- Back-to-back: the next request can be accepted on the edge where resp is high. A requester that drops valid on seeing resp is therefore not re-served.
- The resp data register holds its value until the next response.

## Structure
- **Package `mem_ctrl_pkg`:**
  - Size enum (`SZ_B`/`SZ_H`/`SZ_W`).
  - State enum (IDLE/READ/WRITE).
  - `IO_SEL` constant.
  - Requester-id enum (IF/LS).
  - An extension function (size, signed, raw → 32b).
- A single module. No sub-module is needed.

## Test plan
- **Word fetch:** RAM[0x100..0x103] = 13 05 00 00; fetch at 0x100 → `mem_a` 0x100..0x103 on consecutive cycles; `if_resp_data` = 0x00000513, 6 cycles after accept.
- **Signed load:**
  - LB signed at 0x200 holding 0x80 → `ls_resp_rdata` = 0xFFFFFF80.
  - LHU at 0x200 with 0x80 0x12 → 0x00001280.
- **Arbitration:** simultaneous fetch 0x0 and SW 0xDEADBEEF at 0x400 → store served first (bytes EF BE AD DE, `mem_wr` = 1); then the fetch; RAM[0x400] reads back 0xDEADBEEF.
- **IO stall:** SB 0x41 to 0x30000 with `io_buffer_full` high 3 cycles → `mem_wr` stays 0 for those cycles; exactly one write of 0x41; `ls_resp_valid` follows.
- **Flush:** flush after the 2nd fetch byte → no `if_resp_valid`; IDLE next cycle; a following LW completes normally.
- **Reset and rdy:**
  - `rst_in` mid-store → outputs return to reset values, no resp.
  - `rdy_in` low during a store → `mem_wr` = 0, state held, and each byte is written exactly once.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_e;

    // Index of the final byte of a transfer (N-1); unknown encodings act as word.
    function automatic logic [1:0] last_idx(size_e size);
        case (size)
            SZ_B:    return 2'd0;
            SZ_H:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(size_e size, logic sgn, logic [31:0] raw);
        case (size)
            SZ_B:    return {{24{sgn & raw[7]}}, raw[7:0]};
            SZ_H:    return {{16{sgn & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Serialises word fetches and 1/2/4-byte loads/stores onto an 8-bit synchronous
// RAM/IO bus, reassembling little-endian read data with optional sign extension.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        flush_in,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,
    input  logic        ls_req_valid,
    input  logic        ls_req_we,
    input  logic [1:0]  ls_req_size,
    input  logic        ls_req_signed,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_resp_valid,
    output logic [31:0] ls_resp_rdata
);

    state_e      state_q, state_d;
    req_id_e     id_q, id_d;
    size_e       size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] raw_q, raw_d;
    logic [1:0]  k_q, k_d;
    logic [1:0]  cap_q, cap_d;
    logic        wait_q, wait_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic        mem_wr_q, mem_wr_d;
    logic        if_vld_q, if_vld_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_vld_q, ls_vld_d;
    logic [31:0] ls_data_q, ls_data_d;

    logic [1:0] last;
    logic [1:0] k_nxt;
    logic       accept_if;
    logic       stall;
    logic       abort;
    logic       rd_done;
    logic       wr_done;

    assign last      = last_idx(size_q);
    assign k_nxt     = k_q + 2'd1;
    assign accept_if = if_req_valid && !flush_in;
    assign stall     = (state_q == WRITE) && mem_wr_q && (addr_q[17:16] == IO_SEL)
                       && io_buffer_full;
    assign abort     = (state_q == READ) && (id_q == REQ_IF) && flush_in;
    assign rd_done   = (state_q == READ) && !wait_q && (cap_q == last);
    assign wr_done   = (state_q == WRITE) && mem_wr_q && !stall && (k_q == last);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            id_q       <= REQ_IF;
            size_q     <= SZ_W;
            sgn_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            raw_q      <= '0;
            k_q        <= '0;
            cap_q      <= '0;
            wait_q     <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_vld_q   <= 1'b0;
            if_data_q  <= '0;
            ls_vld_q   <= 1'b0;
            ls_data_q  <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            id_q       <= id_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            raw_q      <= raw_d;
            k_q        <= k_d;
            cap_q      <= cap_d;
            wait_q     <= wait_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_vld_q   <= if_vld_d;
            if_data_q  <= if_data_d;
            ls_vld_q   <= ls_vld_d;
            ls_data_q  <= ls_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ls_req_valid)   state_d = ls_req_we ? WRITE : READ;
                else if (accept_if) state_d = READ;
            end
            READ:    if (abort || rd_done) state_d = IDLE;
            WRITE:   if (wr_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        id_d       = id_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        raw_d      = raw_q;
        k_d        = k_q;
        cap_d      = cap_q;
        wait_d     = wait_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_vld_d   = 1'b0;
        if_data_d  = if_data_q;
        ls_vld_d   = 1'b0;
        ls_data_d  = ls_data_q;

        case (state_q)
            IDLE: begin
                mem_a_d  = '0;
                mem_wr_d = 1'b0;
                k_d      = '0;
                cap_d    = '0;
                wait_d   = 1'b1;
                raw_d    = '0;
                if (ls_req_valid) begin
                    id_d       = REQ_LS;
                    size_d     = size_e'(ls_req_size);
                    sgn_d      = ls_req_signed;
                    addr_d     = ls_req_addr;
                    wdata_d    = ls_req_wdata;
                    mem_a_d    = ls_req_addr;
                    mem_wr_d   = ls_req_we;
                    mem_dout_d = ls_req_we ? ls_req_wdata[7:0] : mem_dout_q;
                end else if (accept_if) begin
                    id_d    = REQ_IF;
                    size_d  = SZ_W;
                    sgn_d   = 1'b0;
                    addr_d  = if_req_addr;
                    mem_a_d = if_req_addr;
                end
            end
            READ: begin
                // Issue runs one byte ahead of capture; the bus parks at 0 once all bytes are out.
                if (k_q != last) begin
                    k_d     = k_nxt;
                    mem_a_d = addr_q + {30'd0, k_nxt};
                end else begin
                    mem_a_d = '0;
                end
                if (wait_q) begin
                    wait_d = 1'b0;
                end else begin
                    raw_d[{cap_q, 3'b000} +: 8] = mem_din;
                    cap_d = cap_q + 2'd1;
                    if (cap_q == last) begin
                        if (id_q == REQ_IF) begin
                            if_vld_d  = 1'b1;
                            if_data_d = extend(size_q, sgn_q, raw_d);
                        end else begin
                            ls_vld_d  = 1'b1;
                            ls_data_d = extend(size_q, sgn_q, raw_d);
                        end
                    end
                end
                if (abort) begin
                    mem_a_d  = '0;
                    if_vld_d = 1'b0;
                end
            end
            WRITE: begin
                if (mem_wr_q && !stall) begin
                    if (k_q == last) begin
                        mem_wr_d = 1'b0;
                        mem_a_d  = '0;
                        ls_vld_d = 1'b1;
                    end else begin
                        k_d        = k_nxt;
                        mem_a_d    = addr_q + {30'd0, k_nxt};
                        mem_dout_d = wdata_q[{k_nxt, 3'b000} +: 8];
                    end
                end
            end
            default: begin
                mem_a_d  = '0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    // Gating with rdy_in keeps a frozen write cycle from hitting the RAM twice.
    assign mem_a         = mem_a_q;
    assign mem_dout      = mem_dout_q;
    assign mem_wr        = mem_wr_q & rdy_in & ~stall;
    assign if_resp_valid = if_vld_q;
    assign if_resp_data  = if_data_q;
    assign ls_resp_valid = ls_vld_q;
    assign ls_resp_rdata = ls_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed self-checking bench for mem_ctrl with a behavioural 8-bit RAM/IO bus.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        flush_in = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = '0;
    logic        if_resp_valid;
    logic [31:0] if_resp_data;
    logic        ls_req_valid = 1'b0;
    logic        ls_req_we = 1'b0;
    logic [1:0]  ls_req_size = 2'd0;
    logic        ls_req_signed = 1'b0;
    logic [31:0] ls_req_addr = '0;
    logic [31:0] ls_req_wdata = '0;
    logic        ls_resp_valid;
    logic [31:0] ls_resp_rdata;

    int checks = 0;
    int failures = 0;

    logic [7:0] ram [0:4095];
    int         wr_cnt = 0;
    int         io_cnt = 0;
    logic [7:0] io_last = '0;

    mem_ctrl dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full),
        .flush_in      (flush_in),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_we     (ls_req_we),
        .ls_req_size   (ls_req_size),
        .ls_req_signed (ls_req_signed),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wdata  (ls_req_wdata),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_rdata (ls_resp_rdata)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM: read data appears the cycle after the address; IO writes are logged.
    always @(posedge clk_in) begin
        if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) begin
                io_cnt  <= io_cnt + 1;
                io_last <= mem_dout;
            end else begin
                ram[mem_a[11:0]] <= mem_dout;
                wr_cnt <= wr_cnt + 1;
            end
        end
        mem_din <= ram[mem_a[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic ls_xfer(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output int cyc);
        ls_req_we     = we;
        ls_req_size   = sz;
        ls_req_signed = sg;
        ls_req_addr   = a;
        ls_req_wdata  = wd;
        ls_req_valid  = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!ls_resp_valid && cyc < 40);
        check("ls_resp_seen", {31'd0, ls_resp_valid}, 32'd1);
        rd = ls_resp_rdata;
        ls_req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    int          cyc;
    int          base;
    int          hits;
    logic [7:0]  sw_bytes [4];

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
        ram[12'h200] = 8'h80; ram[12'h201] = 8'h12; ram[12'h202] = 8'h34; ram[12'h203] = 8'h56;
        ram[12'h000] = 8'h11; ram[12'h001] = 8'h22; ram[12'h002] = 8'h33; ram[12'h003] = 8'h44;
        ram[12'hFFF] = 8'hAB;
        sw_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        step();
        step();
        check("rst_mem_a", mem_a, 32'h0);
        check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
        check("rst_if_vld", {31'd0, if_resp_valid}, 32'h0);
        check("rst_ls_vld", {31'd0, ls_resp_valid}, 32'h0);
        check("rst_if_data", if_resp_data, 32'h0);
        check("rst_ls_data", ls_resp_rdata, 32'h0);
        rst_in = 1'b0;
        step();

        // Word fetch: addresses on consecutive cycles, response 6 cycles after accept
        if_req_addr  = 32'h100;
        if_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("fetch_addr", mem_a, 32'h100 + 32'(k));
            check("fetch_rd", {31'd0, mem_wr}, 32'h0);
        end
        step();
        check("fetch_early", {31'd0, if_resp_valid}, 32'h0);
        check("fetch_a_park", mem_a, 32'h0);
        step();
        check("fetch_vld", {31'd0, if_resp_valid}, 32'h1);
        check("fetch_data", if_resp_data, 32'h00000513);
        if_req_valid = 1'b0;
        step();
        check("fetch_pulse", {31'd0, if_resp_valid}, 32'h0);
        check("fetch_hold", if_resp_data, 32'h00000513);

        // Loads: sign/zero extension and latency N+2
        ls_xfer(1'b0, 2'd0, 1'b1, 32'h200, '0, rd, cyc);
        check("lb_data", rd, 32'hFFFFFF80);
        check("lb_lat", 32'(cyc), 32'd3);
        ls_xfer(1'b0, 2'd1, 1'b0, 32'h200, '0, rd, cyc);
        check("lhu_data", rd, 32'h00001280);
        check("lhu_lat", 32'(cyc), 32'd4);
        ls_xfer(1'b0, 2'd0, 1'b0, 32'h200, '0, rd, cyc);
        check("lbu_data", rd, 32'h00000080);
        ls_xfer(1'b0, 2'd2, 1'b1, 32'h200, '0, rd, cyc);
        check("lw_data", rd, 32'h56341280);
        check("lw_lat", 32'(cyc), 32'd6);

        // Arbitration: store wins, fetch follows
        if_req_addr   = 32'h0;
        if_req_valid  = 1'b1;
        ls_req_we     = 1'b1;
        ls_req_size   = 2'd2;
        ls_req_signed = 1'b0;
        ls_req_addr   = 32'h400;
        ls_req_wdata  = 32'hDEADBEEF;
        ls_req_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("sw_wr", {31'd0, mem_wr}, 32'h1);
            check("sw_addr", mem_a, 32'h400 + 32'(k));
            check("sw_byte", {24'd0, mem_dout}, {24'd0, sw_bytes[k]});
        end
        step();
        check("sw_resp", {31'd0, ls_resp_valid}, 32'h1);
        check("sw_resp_wr", {31'd0, mem_wr}, 32'h0);
        check("sw_no_if", {31'd0, if_resp_valid}, 32'h0);
        ls_req_valid = 1'b0;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!if_resp_valid && cyc < 40);
        check("arb_if_seen", {31'd0, if_resp_valid}, 32'h1);
        check("arb_if_data", if_resp_data, 32'h44332211);
        check("arb_if_lat", 32'(cyc), 32'd6);
        if_req_valid = 1'b0;
        ls_xfer(1'b0, 2'd2, 1'b0, 32'h400, '0, rd, cyc);
        check("sw_readback", rd, 32'hDEADBEEF);

        // Address wraps from 0xFFFFFFFF to 0
        ls_xfer(1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, '0, rd, cyc);
        check("wrap_lhu", rd, 32'h000011AB);
        ls_xfer(1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, '0, rd, cyc);
        check("wrap_lb", rd, 32'hFFFFFFAB);

        // IO stall: three blocked cycles then exactly one write
        step();
        base = io_cnt;
        io_buffer_full = 1'b1;
        ls_req_we     = 1'b1;
        ls_req_size   = 2'd0;
        ls_req_addr   = 32'h00030000;
        ls_req_wdata  = 32'h00000041;
        ls_req_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("io_stall_wr", {31'd0, mem_wr}, 32'h0);
            check("io_stall_addr", mem_a, 32'h00030000);
        end
        io_buffer_full = 1'b0;
        #1;
        check("io_go_wr", {31'd0, mem_wr}, 32'h1);
        check("io_go_byte", {24'd0, mem_dout}, 32'h41);
        step();
        check("io_resp", {31'd0, ls_resp_valid}, 32'h1);
        check("io_resp_wr", {31'd0, mem_wr}, 32'h0);
        check("io_count", 32'(io_cnt - base), 32'd1);
        check("io_byte", {24'd0, io_last}, 32'h41);
        ls_req_valid = 1'b0;

        // Flush after the second fetch byte
        step();
        if_req_addr  = 32'h100;
        if_req_valid = 1'b1;
        step();
        step();
        check("flush_pre_addr", mem_a, 32'h101);
        flush_in     = 1'b1;
        if_req_valid = 1'b0;
        step();
        flush_in = 1'b0;
        check("flush_a_park", mem_a, 32'h0);
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            if (if_resp_valid) hits++;
            step();
        end
        check("flush_no_resp", 32'(hits), 32'd0);
        ls_xfer(1'b0, 2'd2, 1'b0, 32'h200, '0, rd, cyc);
        check("flush_lw", rd, 32'h56341280);
        check("flush_lw_lat", 32'(cyc), 32'd6);

        // Reset mid-store abandons the access
        step();
        ls_req_we    = 1'b1;
        ls_req_size  = 2'd2;
        ls_req_addr  = 32'h500;
        ls_req_wdata = 32'hCAFEF00D;
        ls_req_valid = 1'b1;
        step();
        step();
        check("midrst_busy", {31'd0, mem_wr}, 32'h1);
        rst_in = 1'b1;
        ls_req_valid = 1'b0;
        step();
        check("midrst_a", mem_a, 32'h0);
        check("midrst_wr", {31'd0, mem_wr}, 32'h0);
        check("midrst_dout", {24'd0, mem_dout}, 32'h0);
        check("midrst_ls_data", ls_resp_rdata, 32'h0);
        check("midrst_if_data", if_resp_data, 32'h0);
        rst_in = 1'b0;
        hits = 0;
        for (int k = 0; k < 6; k++) begin
            if (ls_resp_valid) hits++;
            step();
        end
        check("midrst_no_resp", 32'(hits), 32'd0);

        // rdy_in low during a store freezes it without duplicate writes
        base = wr_cnt;
        ls_req_we    = 1'b1;
        ls_req_size  = 2'd2;
        ls_req_addr  = 32'h600;
        ls_req_wdata = 32'h01020304;
        ls_req_valid = 1'b1;
        step();
        check("rdy_first_wr", {31'd0, mem_wr}, 32'h1);
        rdy_in = 1'b0;
        #1;
        check("rdy_gate_wr", {31'd0, mem_wr}, 32'h0);
        step();
        check("rdy_hold_a", mem_a, 32'h600);
        check("rdy_hold_dout", {24'd0, mem_dout}, 32'h04);
        rdy_in = 1'b1;
        step();
        check("rdy_adv_a", mem_a, 32'h601);
        rdy_in = 1'b0;
        step();
        step();
        check("rdy_hold2_a", mem_a, 32'h601);
        check("rdy_hold2_wr", {31'd0, mem_wr}, 32'h0);
        rdy_in = 1'b1;
        cyc = 0;
        while (!ls_resp_valid && cyc < 20) begin
            step();
            cyc++;
        end
        check("rdy_resp", {31'd0, ls_resp_valid}, 32'h1);
        check("rdy_wr_count", 32'(wr_cnt - base), 32'd4);
        ls_req_valid = 1'b0;
        ls_xfer(1'b0, 2'd2, 1'b0, 32'h600, '0, rd, cyc);
        check("rdy_readback", rd, 32'h01020304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
